// File: rtl/pipe_pkg.sv
// Shared types for the pipe_chain skid pipeline.
// Stage state encoding and occupancy width helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } stage_st_e;

    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// Valid/ready/data link between pipeline stages.
// master drives valid/data, slave drives ready.
interface pipe_chain_if #(
    parameter int W_DATA = 32
) ();
    logic              valid;
    logic              ready;
    logic [W_DATA-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// One two-entry skid stage: main register plus skid register.
// Upstream ready is a flop, so no path from downstream ready.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int W_DATA = 32
) (
    input  logic         i_clk,
    input  logic         resetn,
    input  logic         i_flush,
    pipe_chain_if.slave  up,
    pipe_chain_if.master dn
);

    stage_st_e         state_q;
    stage_st_e         state_d;
    logic              rdy_q;
    logic [W_DATA-1:0] main_q;
    logic [W_DATA-1:0] skid_q;
    logic              accept;
    logic              drain;
    logic              ld_main;
    logic              ld_skid;
    logic              ld_from_skid;

    assign accept   = up.valid && rdy_q;
    assign drain    = (state_q != ST_EMPTY) && dn.ready;
    assign up.ready = rdy_q;
    assign dn.valid = (state_q != ST_EMPTY);
    assign dn.data  = main_q;

    // Next state and register load selects; flush wins over handshakes.
    always_comb begin
        state_d      = state_q;
        ld_main      = 1'b0;
        ld_skid      = 1'b0;
        ld_from_skid = 1'b0;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_HALF;
                        ld_main = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (accept && drain) begin
                        ld_main = 1'b1;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        ld_skid = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d      = ST_HALF;
                        ld_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State register and registered upstream ready (low after flush).
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= !i_flush && (state_d != ST_FULL);
        end
    end

    // Payload registers; main only moves when its word is consumed.
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main)           main_q <= up.data;
            else if (ld_from_skid) main_q <= skid_q;
            if (ld_skid)           skid_q <= up.data;
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// DEPTH skid stages in series with occupancy and stall counters.
// Stall counter built only when PIPE_CHAIN_STALL_CNT_EN is defined.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter  int W_DATA = 32,
    parameter  int DEPTH  = 2,
    localparam int W_OCC  = occ_width(DEPTH)
) (
    input  logic              i_clk,
    input  logic              resetn,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [W_DATA-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [W_DATA-1:0] o_data,
    output logic [W_OCC-1:0]  o_occ,
    output logic [15:0]       o_stall_cnt
);

    pipe_chain_if #(.W_DATA(W_DATA)) link [0:DEPTH] ();

    logic             acc;
    logic             drn;
    logic [W_OCC-1:0] occ_q;

    assign link[0].valid     = i_valid;
    assign link[0].data      = i_data;
    assign o_ready           = link[0].ready;
    assign o_valid           = link[DEPTH].valid;
    assign o_data            = link[DEPTH].data;
    assign link[DEPTH].ready = i_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_skid_stage #(.W_DATA(W_DATA)) u_stage (
            .i_clk  (i_clk),
            .resetn (resetn),
            .i_flush(i_flush),
            .up     (link[g]),
            .dn     (link[g+1])
        );
    end

    assign acc   = i_valid && o_ready && !i_flush;
    assign drn   = o_valid && i_ready && !i_flush;
    assign o_occ = occ_q;

    // Occupancy: +1 on accept, -1 on drain, cleared by flush.
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            occ_q <= '0;
        end else if (i_flush) begin
            occ_q <= '0;
        end else if (acc && !drn) begin
            occ_q <= occ_q + W_OCC'(1);
        end else if (!acc && drn) begin
            occ_q <= occ_q - W_OCC'(1);
        end
    end

`ifdef PIPE_CHAIN_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles where output waits on downstream.
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            stall_q <= '0;
        end else if (o_valid && !i_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Directed scoreboard bench for pipe_chain (DEPTH=2, W_DATA=32).
// Expected words queued at acceptance, popped at delivery.
module tb_pipe_chain;
    import pipe_pkg::*;

    localparam int W  = 32;
    localparam int D  = 2;
    localparam int WO = occ_width(D);

    logic          i_clk   = 1'b0;
    logic          resetn  = 1'b0;
    logic          i_flush = 1'b0;
    logic [WO-1:0] o_occ;
    logic [15:0]   o_stall_cnt;

    pipe_chain_if #(.W_DATA(W)) up_if ();
    pipe_chain_if #(.W_DATA(W)) dn_if ();

    pipe_chain #(.W_DATA(W), .DEPTH(D)) dut (
        .i_clk      (i_clk),
        .resetn     (resetn),
        .i_flush    (i_flush),
        .i_valid    (up_if.valid),
        .o_ready    (up_if.ready),
        .i_data     (up_if.data),
        .o_valid    (dn_if.valid),
        .i_ready    (dn_if.ready),
        .o_data     (dn_if.data),
        .o_occ      (o_occ),
        .o_stall_cnt(o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    int            tests   = 0;
    int            fails   = 0;
    int            cyc     = 0;
    int            acc_n   = 0;
    int            drn_n   = 0;
    int            acc_cyc = -1;
    int            drn_cyc = -1;
    logic [W-1:0]  sb[$];
    logic [WO-1:0] occ_m   = '0;
    logic [15:0]   stall_m = '0;
    bit            seq     = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check counters, track handshakes, advance to edge+1.
    task automatic step();
        logic         acc;
        logic         drn;
        logic [W-1:0] e;
        @(negedge i_clk);
        chk("occ", o_occ, occ_m);
        chk("stall", o_stall_cnt, stall_m);
        acc = up_if.valid && up_if.ready && !i_flush && resetn;
        drn = dn_if.valid && dn_if.ready && !i_flush && resetn;
        if (i_flush) sb.delete();
        if (drn) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("data", dn_if.data, e);
            end
            drn_n++;
            drn_cyc = cyc;
        end
        if (acc) begin
            sb.push_back(up_if.data);
            acc_n++;
            acc_cyc = cyc;
        end
`ifdef PIPE_CHAIN_STALL_CNT_EN
        if (resetn && dn_if.valid && !dn_if.ready && stall_m != 16'hFFFF)
            stall_m = stall_m + 16'd1;
`endif
        occ_m = i_flush ? '0 : occ_m + WO'(acc) - WO'(drn);
        @(posedge i_clk);
        #1;
        cyc++;
        if (acc && seq) up_if.data = up_if.data + 1;
    endtask

    initial begin
        int          a0;
        int          d0;
        logic [15:0] s;
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.ready = 1'b1;

        // reset state
        #1;
        chk("rst_valid", dn_if.valid, 0);
        chk("rst_ready", up_if.ready, 0);
        chk("rst_occ", o_occ, 0);
        chk("rst_stall", o_stall_cnt, 0);
        chk("rst_data", dn_if.data, 0);
        @(negedge i_clk);
        #2 resetn = 1'b1;
        chk("rdy_before_edge", up_if.ready, 0);
        @(posedge i_clk);
        #1;
        chk("rdy_after_edge", up_if.ready, 1);

        // single word latency
        up_if.valid = 1'b1;
        up_if.data  = 32'hDEAD_BEEF;
        step();
        up_if.valid = 1'b0;
        chk("v_c1", dn_if.valid, 0);
        step();
        chk("v_c2", dn_if.valid, 1);
        chk("d_c2", dn_if.data, 32'hDEAD_BEEF);
        step();
        chk("occ_c3", o_occ, 0);
        chk("lat1", drn_cyc - acc_cyc, D);

        // backpressure fill
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = '0;
        seq         = 1'b1;
        a0          = acc_n;
        repeat (10) step();
        chk("fill_acc", acc_n - a0, 4);
        chk("fill_rdy", up_if.ready, 0);
        chk("fill_occ", o_occ, 4);
        s = o_stall_cnt;
        step();
`ifdef PIPE_CHAIN_STALL_CNT_EN
        chk("stall_inc", o_stall_cnt, s + 16'd1);
`else
        chk("stall_zero", o_stall_cnt, 16'd0);
`endif

        // full throughput
        dn_if.ready = 1'b1;
        repeat (4) step();
        d0 = drn_n;
        a0 = acc_n;
        repeat (10) step();
        chk("tput_drn", drn_n - d0, 10);
        chk("tput_acc", acc_n - a0, 10);
        up_if.valid = 1'b0;
        seq         = 1'b0;
        repeat (8) step();
        chk("drain_sb", sb.size(), 0);
        chk("drain_occ", o_occ, 0);

        // flush at occupancy 3 with a word offered
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 32'h100;
        seq         = 1'b1;
        a0          = acc_n;
        for (int i = 0; i < 10 && acc_n - a0 < 3; i++) step();
        chk("pre_flush_occ", o_occ, 3);
        seq         = 1'b0;
        up_if.data  = 32'hBAD0_0BAD;
        i_flush     = 1'b1;
        step();
        i_flush     = 1'b0;
        up_if.valid = 1'b0;
        chk("fl_occ", o_occ, 0);
        chk("fl_valid", dn_if.valid, 0);
        chk("fl_ready", up_if.ready, 0);
        step();
        chk("fl_ready_back", up_if.ready, 1);
        dn_if.ready = 1'b1;
        up_if.valid = 1'b1;
        up_if.data  = 32'h55;
        step();
        up_if.valid = 1'b0;
        repeat (5) step();
        chk("fl_sb", sb.size(), 0);

        // async reset mid-stream
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 32'h200;
        seq         = 1'b1;
        for (int i = 0; i < 10 && occ_m != 2; i++) step();
        chk("pre_rst_occ", o_occ, 2);
        #2 resetn = 1'b0;
        #1;
        chk("ar_valid", dn_if.valid, 0);
        chk("ar_ready", up_if.ready, 0);
        chk("ar_occ", o_occ, 0);
        chk("ar_data", dn_if.data, 0);
        chk("ar_stall", o_stall_cnt, 0);
        sb.delete();
        occ_m       = '0;
        stall_m     = '0;
        seq         = 1'b0;
        up_if.valid = 1'b0;
        dn_if.ready = 1'b1;
        @(negedge i_clk);
        #2 resetn = 1'b1;
        @(posedge i_clk);
        #1;
        chk("ar_rdy_back", up_if.ready, 1);
        up_if.valid = 1'b1;
        up_if.data  = 32'h77;
        step();
        up_if.valid = 1'b0;
        repeat (4) step();
        chk("lat2", drn_cyc - acc_cyc, D);

        // long stall for saturation
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 32'h300;
        seq         = 1'b1;
        repeat (70000) step();
`ifdef PIPE_CHAIN_STALL_CNT_EN
        chk("stall_sat", o_stall_cnt, 16'hFFFF);
`else
        chk("stall_off", o_stall_cnt, 16'd0);
`endif
        seq         = 1'b0;
        up_if.valid = 1'b0;
        dn_if.ready = 1'b1;
        repeat (8) step();
        chk("end_sb", sb.size(), 0);
        chk("end_occ", o_occ, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL have parameter W_DATA, default 32: data payload width in bits, legal 1..256.
REQ-002 SHALL have parameter DEPTH, default 2: number of skid stages in series, legal 1..8.
REQ-003 SHALL have localparam W_OCC, fixed at $clog2(2*DEPTH+1): occupancy counter width.
REQ-004 SHALL have port i_clk  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_flush  input  1  synchronous discard of all held words.
REQ-007 SHALL have port i_valid  input  1  upstream word present.
REQ-008 SHALL have port o_ready  output  1  chain accepts a word this cycle; registered.
REQ-009 SHALL have port i_data  input  W_DATA  upstream payload.
REQ-010 SHALL have port o_valid  output  1  downstream word present.
REQ-011 SHALL have port i_ready  input  1  downstream accepts this cycle.
REQ-012 SHALL have port o_data  output  W_DATA  downstream payload; registered.
REQ-013 SHALL have port o_occ  output  W_OCC  words currently held, 0..2*DEPTH.
REQ-014 SHALL have port o_stall_cnt  output  16  count of cycles with o_valid=1 and i_ready=0.

Function
REQ-015 SHALL transfer a word on any port where valid and ready are both 1 on a rising edge; payload SHALL NOT change while valid=1 and ready=0.
REQ-016 SHALL implement each stage as a state machine EMPTY/HALF/FULL: EMPTY->HALF on accept; HALF->FULL on accept without drain; FULL->HALF on drain; HALF->EMPTY on drain without accept; HALF stays HALF on simultaneous accept and drain.
REQ-017 SHALL drive each stage's upstream ready as (state != FULL), taken from a register and with no combinational path from i_ready to o_ready.
REQ-018 SHALL deliver an accepted word on o_valid exactly DEPTH cycles after acceptance when no backpressure is applied.
REQ-019 SHALL sustain one transfer per cycle at steady state with i_ready held at 1.
REQ-020 SHALL preserve word order with no loss or duplication under any i_valid/i_ready pattern.
REQ-021 SHALL update o_occ every cycle as previous + accept - drain; the simultaneous case leaves it unchanged; o_occ never exceeds 2*DEPTH.
REQ-022 SHALL, when i_flush=1, force all stages to EMPTY and o_occ to 0 on that edge, and ignore any input or output handshake in that cycle; o_ready SHALL be 0 in the cycle after a flush.
REQ-023 SHALL increment o_stall_cnt and saturate at 16'hFFFF; i_flush SHALL NOT clear it.

Reset
REQ-024 SHALL, while resetn=0, immediately hold o_valid=0, o_ready=0, o_occ=0, o_stall_cnt=0, o_data=0, and all stages in EMPTY.
REQ-025 SHALL raise o_ready on the first rising edge after resetn deasserts; any word in flight when reset asserts is lost.

Configuration
REQ-026 SHALL, when PIPE_CHAIN_STALL_CNT_EN is defined, implement o_stall_cnt as in REQ-014 and REQ-023.
REQ-027 SHALL, when PIPE_CHAIN_STALL_CNT_EN is undefined, tie o_stall_cnt to 0 and infer no counter flops; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL place the stage-state enum (EMPTY/HALF/FULL) and the helper function for W_OCC in the shared package pipe_pkg.
REQ-029 SHALL implement one stage as sub-module pipe_skid_stage (W_DATA parameter, valid/ready on both sides) and instantiate it DEPTH times through a generate loop.
REQ-030 SHALL keep the occupancy and stall counters in the pipe_chain top module, not in the stages.

Verification
REQ-031 SHALL check: DEPTH=2, i_ready=1, one word 32'hDEAD_BEEF accepted at cycle 0 -> o_valid=1 with that data at cycle 2, o_occ back to 0 at cycle 3.
REQ-032 SHALL check: DEPTH=2, i_ready=0, i_valid=1 continuously -> exactly 4 words accepted, o_ready=0, o_occ=4, o_stall_cnt increments every cycle.
REQ-033 SHALL check: full chain, then i_ready=1 with i_valid=1 continuously -> one transfer per cycle, with in-order sequence 0,1,2,... on o_data.
REQ-034 SHALL check: o_occ=3 with i_flush=1 and a simultaneous i_valid=1 -> o_occ=0 and o_valid=0 next cycle, flushed input word never appears, o_ready=0 for one cycle.
REQ-035 SHALL check: resetn pulled low mid-stream with o_occ=2 -> o_valid, o_ready and o_occ go to 0 without a clock edge, and first new word latency is DEPTH after release.
REQ-036 SHALL check: with macro defined, 70000 stall cycles -> o_stall_cnt=16'hFFFF; with macro undefined, o_stall_cnt=0 throughout.
